// File: rtl/uart_echo_checker_if.sv
// uart_echo_checker_if: control, status and serial lines of the echo checker
interface uart_echo_checker_if;
  logic       start;
  logic       rx;
  logic       tx;
  logic       busy;
  logic       done;
  logic       pass;
  logic       timeout;
  logic [7:0] err_count;
  logic [7:0] last_sent;
  logic [7:0] last_rcvd;
  modport master (output start, rx, input tx, busy, done, pass, timeout, err_count, last_sent, last_rcvd);
  modport slave  (input start, rx, output tx, busy, done, pass, timeout, err_count, last_sent, last_rcvd);
endinterface

// File: rtl/uart_echo_checker.sv
// uart_echo_checker: sends a byte pattern over 8N1, checks each echo, counts errors and timeouts
// UART_ECHO_CHK_LFSR_EN selects an x^8+x^6+x^5+x^4+1 LFSR pattern instead of SEED+k
module uart_echo_checker #(
  parameter int         SYSTEM_CLOCK = 32000000,
  parameter int         BAUD_RATE    = 9600,
  parameter int         NUM_BYTES    = 16,
  parameter logic [7:0] SEED         = 8'h41,
  parameter int         TIMEOUT_BITS = 20
) (
  input logic clk,
  input logic rst,
  uart_echo_checker_if.slave bus
);
  localparam int CPB  = SYSTEM_CLOCK / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int TMO  = TIMEOUT_BITS * CPB;
  typedef enum logic [2:0] {IDLE, SEND, WAIT_ECHO, COMPARE, NEXT, DONE} state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;
  state_t      state, state_n;
  rstate_t     rstate, rstate_n;
  logic        go, expire, cmp_err, last, tx_fin, hwr, ovr;
  logic [1:0]  inc;
  logic [8:0]  sum;
  logic [7:0]  k, pat, err, ls, lr, h_data, rsh;
  logic        h_ferr, h_valid, tmo_flag, txr, tx_act, s1, s2, s3, rdone;
  logic [8:0]  tx_sh;
  logic [3:0]  tx_bit;
  logic [2:0]  rbit;
  logic [31:0] tx_cnt, tmo, rcnt;
`ifdef UART_ECHO_CHK_LFSR_EN
  logic [7:0]  lfsr;
  assign pat = lfsr;
`else
  assign pat = SEED + k;
`endif
  assign last   = k == 8'(NUM_BYTES - 1);
  assign tx_fin = tx_act && tx_bit == 4'd9 && tx_cnt == 32'(CPB - 1);
  assign rdone  = rstate == R_STOP && rcnt == 32'(CPB - 1);
  assign hwr    = rdone && (state == SEND || state == WAIT_ECHO);
  assign ovr    = hwr && h_valid;
  assign inc    = {1'b0, ovr} + {1'b0, expire | cmp_err};
  assign sum    = {1'b0, err} + {7'd0, inc};
  always_comb begin
    state_n = state;
    go      = 1'b0;
    expire  = 1'b0;
    cmp_err = 1'b0;
    unique case (state)
      IDLE, DONE: if (bus.start) begin
        state_n = SEND;
        go      = 1'b1;
      end
      SEND:      if (tx_fin) state_n = WAIT_ECHO;
      WAIT_ECHO: if (h_valid) state_n = COMPARE;
                 else if (tmo <= 32'd1) begin
                   state_n = NEXT;
                   expire  = 1'b1;
                 end
      COMPARE: begin
        state_n = NEXT;
        cmp_err = h_data != pat || h_ferr;
      end
      NEXT:    state_n = last ? DONE : SEND;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err      <= '0;
      tmo_flag <= 1'b0;
      k        <= '0;
      h_valid  <= 1'b0;
      h_data   <= '0;
      h_ferr   <= 1'b0;
      lr       <= '0;
      ls       <= '0;
      tmo      <= '0;
      txr      <= 1'b1;
      tx_act   <= 1'b0;
      tx_sh    <= '0;
      tx_bit   <= '0;
      tx_cnt   <= '0;
`ifdef UART_ECHO_CHK_LFSR_EN
      lfsr     <= '0;
`endif
    end else begin
      err <= go ? 8'd0 : sum[8] ? 8'hff : sum[7:0];
      if (go) tmo_flag <= 1'b0;
      else if (expire) tmo_flag <= 1'b1;
      if (go) k <= '0;
      else if (state == NEXT && !last) k <= k + 8'd1;
`ifdef UART_ECHO_CHK_LFSR_EN
      if (go) lfsr <= SEED == 8'd0 ? 8'h01 : SEED;
      else if (state == NEXT) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
      if (go) h_valid <= 1'b0;
      else if (hwr) begin
        h_valid <= 1'b1;
        h_data  <= rsh;
        h_ferr  <= !s2;
      end else if (state == WAIT_ECHO && h_valid) h_valid <= 1'b0;
      if (state == COMPARE) lr <= h_data;
      if (tx_fin) tmo <= 32'(TMO);
      else if (state == WAIT_ECHO && !h_valid) tmo <= tmo - 32'd1;
      if (state == SEND && !tx_act) begin
        tx_act <= 1'b1;
        txr    <= 1'b0;
        tx_sh  <= {1'b1, pat};
        tx_bit <= '0;
        tx_cnt <= '0;
        ls     <= pat;
      end else if (tx_act) begin
        if (tx_cnt == 32'(CPB - 1)) begin
          tx_cnt <= '0;
          if (tx_bit == 4'd9) tx_act <= 1'b0;
          else begin
            tx_bit <= tx_bit + 4'd1;
            txr    <= tx_sh[0];
            tx_sh  <= {1'b1, tx_sh[8:1]};
          end
        end else tx_cnt <= tx_cnt + 32'd1;
      end
    end
  always_comb begin
    rstate_n = rstate;
    unique case (rstate)
      R_IDLE:  if (s3 && !s2) rstate_n = R_START;
      R_START: if (rcnt == 32'(HALF - 1)) rstate_n = s2 ? R_IDLE : R_DATA;
      R_DATA:  if (rcnt == 32'(CPB - 1) && rbit == 3'd7) rstate_n = R_STOP;
      default: if (rcnt == 32'(CPB - 1)) rstate_n = R_IDLE;
    endcase
  end
  // synchronizer resets to the idle line level so release cannot fake a start edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s3     <= 1'b1;
      rstate <= R_IDLE;
      rcnt   <= '0;
      rbit   <= '0;
      rsh    <= '0;
    end else begin
      s1     <= bus.rx;
      s2     <= s1;
      s3     <= s2;
      rstate <= rstate_n;
      rcnt   <= rstate != rstate_n || rstate == R_IDLE || rcnt == 32'(CPB - 1) ? 32'd0 : rcnt + 32'd1;
      rbit   <= rstate != R_DATA ? 3'd0 : rbit + 3'(rcnt == 32'(CPB - 1));
      if (rstate == R_DATA && rcnt == 32'(CPB - 1)) rsh <= {s2, rsh[7:1]};
    end
  assign bus.tx        = txr;
  assign bus.busy      = !(state == IDLE || state == DONE);
  assign bus.done      = state == DONE;
  assign bus.pass      = state == DONE && err == 8'd0;
  assign bus.err_count = err;
  assign bus.timeout   = tmo_flag;
  assign bus.last_sent = ls;
  assign bus.last_rcvd = lr;
endmodule

// File: tb/tb_uart_echo_checker.sv
// tb_uart_echo_checker: scoreboarded runs against loopback, dead line, corrupted echoes and mid-frame reset
module tb_uart_echo_checker;
  localparam int CPB = 10;
  typedef struct packed {logic [7:0] e; logic t; logic p; logic [7:0] lr;} res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold_high = 1'b0;
  logic inv = 1'b0;
  int fcount = 0;
  int flip_frame = -1;
  int stop_frame = -1;
  int errors = 0;
  int checks = 0;
  logic [7:0] q_tx[$];
  res_t q_res[$];
  logic [15:0] q_err[$];
  always #5 clk = ~clk;
  uart_echo_checker_if bus();
  uart_echo_checker #(.SYSTEM_CLOCK(1000000), .BAUD_RATE(100000), .NUM_BYTES(4), .SEED(8'h41), .TIMEOUT_BITS(20))
    dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.rx = hold_high | (bus.tx ^ inv);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got nothing expected an entry", name);
  endtask
  task automatic push_run(input logic [7:0] e, input logic t, input logic p);
    for (int i = 0; i < 4; i++) q_tx.push_back(8'h41 + 8'(i));
    q_res.push_back('{e: e, t: t, p: p, lr: 8'h44});
  endtask
  task automatic pulse();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) miss("done within budget");
    repeat (3) @(negedge clk);
  endtask
  // decodes every tx frame and shapes the echo by toggling inv on bit boundaries
  initial begin
    logic [9:0] f;
    logic ab;
    int idx;
    logic [7:0] eb;
    forever begin
      @(negedge bus.tx);
      idx = fcount;
      fcount++;
      ab = 1'b0;
      for (int b = 0; b < 10; b++) begin
        inv = (idx == flip_frame && b == 1) || (idx == stop_frame && b == 9);
        repeat (CPB / 2) @(posedge clk);
        #1 f[b] = bus.tx;
        ab |= rst;
        repeat (CPB - CPB / 2) @(posedge clk);
      end
      inv = 1'b0;
      if (!ab) begin
        if (q_tx.size() == 0) miss("tx frame expected");
        else begin
          eb = q_tx.pop_front();
          chk("tx byte", 32'(f[8:1]), 32'(eb));
          chk("tx start/stop", 32'({f[9], f[0]}), 32'd2);
        end
      end
    end
  end
  initial begin
    res_t r;
    forever begin
      @(posedge bus.done);
      #1;
      if (q_res.size() == 0) miss("result expected");
      else begin
        r = q_res.pop_front();
        chk("err_count", 32'(bus.err_count), 32'(r.e));
        chk("timeout", 32'(bus.timeout), 32'(r.t));
        chk("pass", 32'(bus.pass), 32'(r.p));
        chk("last_rcvd", 32'(bus.last_rcvd), 32'(r.lr));
      end
    end
  end
  initial begin
    logic [15:0] x;
    forever begin
      @(bus.err_count);
      #1;
      if (bus.err_count != 8'd0) begin
        if (q_err.size() == 0) miss("error event expected");
        else begin
          x = q_err.pop_front();
          chk("error on last_sent", 32'(bus.last_sent), 32'(x[15:8]));
          chk("error on last_rcvd", 32'(bus.last_rcvd), 32'(x[7:0]));
        end
      end
    end
  end
  initial begin
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx", 32'(bus.tx), 32'd1);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset pass", 32'(bus.pass), 32'd0);
    chk("reset err_count", 32'(bus.err_count), 32'd0);
    chk("reset timeout", 32'(bus.timeout), 32'd0);
    chk("reset last_sent", 32'(bus.last_sent), 32'd0);
    chk("reset last_rcvd", 32'(bus.last_rcvd), 32'd0);
    @(negedge clk) rst = 1'b0;
    push_run(8'd0, 1'b0, 1'b1);
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk) #1;
    chk("busy after accept", 32'(bus.busy), 32'd1);
    chk("tx high at accept", 32'(bus.tx), 32'd1);
    @(negedge clk) bus.start = 1'b0;
    @(posedge clk) #1;
    chk("tx falls one cycle later", 32'(bus.tx), 32'd0);
    wait_done();
    hold_high = 1'b1;
    push_run(8'd4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) q_err.push_back({8'h41 + 8'(i), 8'h44});
    pulse();
    wait_done();
    hold_high = 1'b0;
    flip_frame = fcount + 2;
    push_run(8'd1, 1'b0, 1'b0);
    q_err.push_back(16'h4342);
    pulse();
    wait_done();
    flip_frame = -1;
    stop_frame = fcount + 1;
    push_run(8'd1, 1'b0, 1'b0);
    q_err.push_back(16'h4242);
    pulse();
    wait_done();
    stop_frame = -1;
    for (int i = 0; i < 4; i++) q_tx.push_back(8'h41 + 8'(i));
    pulse();
    repeat (150) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid-frame reset tx", 32'(bus.tx), 32'd1);
    chk("mid-frame reset busy", 32'(bus.busy), 32'd0);
    chk("mid-frame reset done", 32'(bus.done), 32'd0);
    chk("mid-frame reset err_count", 32'(bus.err_count), 32'd0);
    repeat (12) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    q_tx.delete();
    push_run(8'd0, 1'b0, 1'b1);
    pulse();
    wait_done();
    push_run(8'd0, 1'b0, 1'b1);
    push_run(8'd0, 1'b0, 1'b1);
    pulse();
    repeat (30) @(negedge clk);
    pulse();
    chk("busy after ignored start", 32'(bus.busy), 32'd1);
    wait_done();
    pulse();
    chk("restart from done", 32'(bus.done), 32'd0);
    wait_done();
    chk("tx scoreboard drained", 32'(q_tx.size()), 32'd0);
    chk("result scoreboard drained", 32'(q_res.size()), 32'd0);
    chk("error scoreboard drained", 32'(q_err.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_echo_checker.md
Name: uart_echo_checker

Overview:
- Host-side initiator that exercises a UART echo responder.
- Transmits a byte sequence, waits for each byte to be echoed back, compares it, and reports errors and timeouts.
- Contains its own 8N1 serializer and deserializer, so it is self-contained and is the far end of the echo link in board and system tests.

Parameters:
- SYSTEM_CLOCK, 32000000: clk frequency in Hz.
- BAUD_RATE, 9600: line rate. CLKS_PER_BIT = SYSTEM_CLOCK/BAUD_RATE (integer division).
- NUM_BYTES, 16: bytes per run, 1..256.
- SEED, 8'h41: first pattern byte.
- TIMEOUT_BITS, 20: echo timeout, counted in bit periods.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a run when not busy.
- rx  in  1  serial input from the responder; asynchronous to clk.
- tx  out  1  serial output to the responder; idle high.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  high in DONE; held until the next accepted start.
- pass  out  1  valid while done; 1 iff err_count==0.
- err_count  out  8  mismatches + framing errors + timeouts; saturates at 255.
- timeout  out  1  sticky; set when any byte times out.
- last_sent  out  8  most recent byte transmitted.
- last_rcvd  out  8  most recent byte compared.

Behaviour:
- Reset: every output is 0 except tx=1. All counters, FSM state and the holding register are cleared. Reset takes effect immediately, including mid-frame.
- TX frame:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT clocks.
  - tx is registered.
- RX path:
  - rx passes through a 2-flop synchronizer.
  - A falling edge while the receiver is idle starts a frame. The start bit is re-checked at mid-bit; if it is high, it is a false start and the receiver returns to idle.
  - Data is sampled at the mid-point of each bit.
  - Stop bit sampled low = framing error. The byte is still delivered, with the ferr flag set.
  - The receiver runs continuously.
- Holding register: one entry (data, ferr, valid).
  - Written when a frame completes in SEND or WAIT_ECHO.
  - A write when already valid overwrites the entry and also counts one error.
  - Frames completing in IDLE or DONE are discarded.
- Pattern: byte k = (SEED + k) mod 256, for k = 0..NUM_BYTES-1.
- FSM:
  - IDLE: on start, clear err_count, timeout, k and holding valid; set busy; go to SEND.
  - SEND: serialize byte k and set last_sent in the first SEND cycle. After the stop bit completes, go to WAIT_ECHO and load the timeout counter with TIMEOUT_BITS*CLKS_PER_BIT.
  - WAIT_ECHO:
    - If holding valid, go to COMPARE and clear valid.
    - Else decrement the counter; at 0, count an error, set timeout, and go to NEXT.
    - If valid and counter expiry occur in the same cycle, valid wins.
  - COMPARE (1 cycle): last_rcvd <= data. Count an error if data != byte k or ferr (one increment even if both).
  - NEXT (1 cycle): if k==NUM_BYTES-1 go to DONE, else k++ and go to SEND. The next frame starts the cycle after NEXT.
  - DONE: busy=0, done=1, pass=(err_count==0). A start pulse goes to IDLE-equivalent clear, then SEND.
- start while busy is ignored.
- Latency: from start accepted to the first tx falling edge is 1 cycle.
- err_count never wraps.

Optional Feature:
- Macro: UART_ECHO_CHK_LFSR_EN.
- Defined: the pattern is an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
  - Byte 0 = SEED; SEED==0 is replaced by 8'h01.
  - The LFSR advances once per NEXT.
  - The expected value is the value sent.
- Undefined: incrementing pattern as specified above; no LFSR logic is present.

Test Plan (SYSTEM_CLOCK=1000000, BAUD_RATE=100000, so 10 clocks/bit; NUM_BYTES=4, SEED=8'h41):
- tx looped straight to rx, start pulse -> tx frames 0x41, 0x42, 0x43, 0x44, each 100 clocks; done=1, pass=1, err_count=0, last_rcvd=0x44.
- rx tied high -> each byte waits 200 clocks then times out; done=1, err_count=4, timeout=1, pass=0.
- Echo model flips bit0 of the 3rd byte -> err_count=1, last_rcvd=0x44, pass=0; the mismatch is attributed to byte 0x43 (observed value 0x42).
- Echo model drives the stop bit low on the 2nd byte -> err_count=1, timeout=0, pass=0.
- Reset asserted mid-frame of the 2nd byte -> tx=1, busy=0, done=0, err_count=0 immediately; after release, a new start runs cleanly to pass=1.
- start pulsed during SEND -> ignored, sequence unchanged; start pulsed in DONE -> counters cleared and the run repeats from 0x41.
